// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit path.
//   tx_state_e : transmitter FSM states (IDLE, START, DATA, STOP)
//   calc_div   : bit period in clocks, rounded to nearest: (clk_hz + baud/2) / baud
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO, DEPTH entries (power of two, 2..256).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (pointers cleared)
//   push_i, data_i  : write strobe and data; accepted when not full, or when
//                     full and a pop happens in the same cycle
//   pop_i, data_o   : read strobe and head-of-queue data (combinational read)
//   full_o, empty_o : status flags
//   level_o         : occupancy, 0..DEPTH
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH=%0d must be a power of two in 2..256", DEPTH);
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign rd_en = pop_i && !empty_o;
    // On full, a same-cycle pop frees the slot the write lands in.
    assign wr_en = push_i && (!full_o || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- 8N1 UART transmitter fed by a write-only byte FIFO.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset; aborts any frame in flight
//   uart_req  : write strobe, one byte enqueued per high cycle (no ready)
//   uart_data : byte to enqueue
//   tx        : serial line, idle high, driven straight from a flop
//   busy      : frame in progress or FIFO non-empty
//   overflow  : sticky, set when a write is dropped on a full FIFO
//   level     : FIFO occupancy
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   uart_req,
    input  logic [7:0]             uart_data,
    output logic                   tx,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned DIV      = calc_div(CLK_HZ, BAUD);
    localparam int unsigned CW       = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: bit period DIV=%0d is below 2 clocks", DIV);
    end

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;

    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_data;
    logic          bit_end;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (uart_req),
        .data_i  (uart_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign bit_end = (cnt_q == DIV_LAST);

    // tx_d is the line value for the current state; registering it delays the
    // line by one clock, so every symbol is still held exactly DIV cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_ONE;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        tx_d     = 1'b1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_data;
                    state_d  = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[bit_q];
                if (bit_end) begin
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign overflow_d = overflow_q | (uart_req & fifo_full & ~fifo_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo -- directed bench for uart_tx_fifo at CLK_HZ=4, BAUD=1
// (4 clocks per bit) and DEPTH=4. Inputs change and outputs are sampled on
// the falling clock edge; frames are checked cycle by cycle.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic       uart_req;
    logic [7:0] uart_data;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [2:0] level;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_fifo #(
        .CLK_HZ (4),
        .BAUD   (1),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_req  (uart_req),
        .uart_data (uart_data),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .level     (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Checks line samples i=first..39 of a frame; sample i is taken at the
    // falling edge after the (i+1)-th rising edge following the pop.
    task automatic frame(input logic [7:0] b, input int first, input string tag);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = first; i < 40; i++) begin
            @(negedge clk);
            check($sformatf("%s_tx%0d", tag, i), tx, bits[i / 4]);
            if (i == 20) check({tag, "_busy"}, busy, 1);
        end
    endtask

    task automatic gap1(input string tag);
        @(negedge clk);
        check(tag, tx, 1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        uart_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] bits;
        rst_n     = 1'b1;
        uart_req  = 1'b0;
        uart_data = 8'h00;
        #2 rst_n  = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_level", level, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte with exact write/pop/start timing.
        uart_req = 1'b1; uart_data = 8'h03;
        @(negedge clk);
        uart_req = 1'b0;
        check("single_lvl_N", level, 1);
        check("single_tx_N", tx, 1);
        @(negedge clk);
        check("single_lvl_N1", level, 0);
        check("single_tx_N1", tx, 1);
        check("single_busy", busy, 1);
        frame(8'h03, 0, "single");
        check("single_done_busy", busy, 0);
        check("single_ovf", overflow, 0);

        // Strobe pair two cycles apart.
        do_reset();
        uart_req = 1'b1; uart_data = 8'h03;
        @(negedge clk);
        uart_req = 1'b0;
        @(negedge clk);
        uart_req = 1'b1; uart_data = 8'hA5;
        @(negedge clk);
        uart_req = 1'b0;
        check("pair_start", tx, 0);
        check("pair_lvl", level, 1);
        frame(8'h03, 1, "pair0");
        gap1("pair_gap");
        frame(8'hA5, 0, "pair1");
        check("pair_busy", busy, 0);
        check("pair_ovf", overflow, 0);

        // Overflow: six back-to-back writes into a 4-deep FIFO.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            uart_req  = 1'b1;
            uart_data = 8'h10 + 8'(k);
            @(negedge clk);
            if (k == 4) begin
                check("ovf_lvl_full", level, 4);
                check("ovf_before", overflow, 0);
            end
        end
        uart_req = 1'b0;
        check("ovf_lvl", level, 4);
        check("ovf_set", overflow, 1);
        frame(8'h10, 4, "ovf10");
        for (int k = 1; k < 5; k++) begin
            gap1($sformatf("ovf_gap%0d", k));
            frame(8'h10 + 8'(k), 0, $sformatf("ovf1%0d", k));
        end
        check("ovf_end_busy", busy, 0);
        check("ovf_end_lvl", level, 0);
        repeat (8) @(negedge clk);
        check("ovf_no_15", tx, 1);
        check("ovf_idle_busy", busy, 0);
        check("ovf_sticky", overflow, 1);

        // Write on full coinciding with the pop.
        do_reset();
        check("fp_ovf_cleared", overflow, 0);
        for (int k = 0; k < 5; k++) begin
            uart_req  = 1'b1;
            uart_data = 8'h20 + 8'(k);
            @(negedge clk);
        end
        uart_req = 1'b0;
        check("fp_lvl_full", level, 4);
        frame(8'h20, 3, "fp20");
        uart_req = 1'b1; uart_data = 8'h25;
        @(negedge clk);
        uart_req = 1'b0;
        check("fp_gap", tx, 1);
        check("fp_lvl_keep", level, 4);
        check("fp_ovf", overflow, 0);
        frame(8'h21, 0, "fp21");
        for (int k = 2; k < 6; k++) begin
            gap1($sformatf("fp_gap%0d", k));
            frame(8'h20 + 8'(k), 0, $sformatf("fp2%0d", k));
        end
        check("fp_end_busy", busy, 0);
        check("fp_end_ovf", overflow, 0);

        // Reset during DATA bit 3 (bit value 0 so the async return to 1 shows).
        do_reset();
        uart_req = 1'b1; uart_data = 8'hF0;
        @(negedge clk);
        uart_req = 1'b0;
        @(negedge clk);
        bits = {1'b1, 8'hF0, 1'b0};
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check($sformatf("mid_tx%0d", i), tx, bits[i / 4]);
        end
        #2;
        rst_n = 1'b0;
        uart_req = 1'b1; uart_data = 8'hAA;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_lvl", level, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("mid_hold_lvl", level, 0);
        check("mid_hold_tx", tx, 1);
        rst_n = 1'b1; uart_data = 8'h55;
        @(negedge clk);
        uart_req = 1'b0;
        check("mid_first_wr", level, 1);
        check("mid_rel_tx", tx, 1);
        @(negedge clk);
        check("mid_rel_tx1", tx, 1);
        frame(8'h55, 0, "mid55");
        check("mid_end_busy", busy, 0);
        check("mid_end_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200: serial bit rate.
REQ-003 SHALL provide parameter DEPTH, default 16: FIFO entries; power of two, 2..256.
REQ-004 SHALL provide port clk  input  1: single clock domain, all logic on the rising edge.
REQ-005 SHALL provide port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 SHALL provide port uart_req  input  1: write strobe; each cycle it is high writes one byte.
REQ-007 SHALL provide port uart_data  input  8: byte to write, sampled when uart_req is high.
REQ-008 SHALL provide port tx  output  1: serial line, 8N1, idle high.
REQ-009 SHALL provide port busy  output  1: high while a frame is on the line or the FIFO is non-empty.
REQ-010 SHALL provide port overflow  output  1: sticky flag, set when a write is dropped.
REQ-011 SHALL provide port level  output  $clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-012 SHALL compute the bit period DIV = (CLK_HZ + BAUD/2) / BAUD clocks at elaboration and SHALL reject DIV < 2 with an elaboration error.
REQ-013 SHALL accept writes on any cycle, with no ready signal; back-to-back strobes on consecutive cycles SHALL each enqueue one byte.
REQ-014 SHALL drop the byte when uart_req is high and the FIFO is full with no pop in the same cycle; level SHALL be unchanged and overflow SHALL set to 1 on the next edge.
REQ-015 SHALL accept the write when the FIFO is full and a pop occurs in the same cycle; level SHALL stay at DEPTH and overflow SHALL not set.
REQ-016 SHALL handle a write into an empty FIFO while TX is IDLE as follows: write on edge N, pop on edge N+1, tx low from edge N+2.
REQ-017 SHALL implement the TX FSM with states IDLE, START, DATA, STOP.
REQ-018 SHALL in IDLE drive tx=1; when the FIFO is non-empty it SHALL pop into the shift register and go to START.
REQ-019 SHALL in START drive tx=0 for DIV cycles, then go to DATA.
REQ-020 SHALL in DATA send 8 bits LSB first, each for DIV cycles, tracked by a 3-bit index that wraps 7->0 on exit to STOP.
REQ-021 SHALL in STOP drive tx=1 for DIV cycles, then return to IDLE.
REQ-022 SHALL insert exactly one idle cycle between frames when data is pending (IDLE->START on the next edge); there SHALL be no other inter-frame gap.
REQ-023 SHALL keep the bit counter modulo DIV, reloaded at every state change so that there is no drift across frames.
REQ-024 SHALL keep FIFO read/write pointers of log2(DEPTH)+1 bits, wrapping naturally; full SHALL mean MSBs differ with remaining bits equal, and empty SHALL mean the pointers are equal.
REQ-025 SHALL keep overflow set until reset; there SHALL be no other clear.
REQ-026 SHALL register tx directly from a flop, with no combinational path to the pin.

Reset
REQ-027 SHALL on rst_n low immediately force tx=1, busy=0, overflow=0, level=0, FSM=IDLE, pointers=0, and discard FIFO contents.
REQ-028 SHALL on reset mid-frame abort the frame, return tx high without waiting for a bit boundary, and not resume the frame after release.
REQ-029 SHALL ignore writes while rst_n is low and SHALL accept the first write on the first edge after release.

Structure
REQ-030 SHALL place the TX state enum and the DIV calculation function in shared package uart_pkg.
REQ-031 SHALL implement the storage as sub-module sync_fifo (parameter DEPTH, width 8, push/pop/full/empty/level), reusable elsewhere.
REQ-032 SHALL fit the whole block in roughly 200 RTL lines.

Verification
REQ-033 SHALL cover single byte: CLK_HZ=4, BAUD=1 (DIV=4), write 0x03 -> tx sequence 0,1,1,0,0,0,0,0,0,1, each held 4 cycles, then busy=0.
REQ-034 SHALL cover a strobe pair: strobes 0x03 then 0xA5 two cycles apart -> frame 0x03, 1 idle cycle, then frame 0xA5 (bits 1,0,1,0,0,1,0,1), and no overflow.
REQ-035 SHALL cover overflow: DEPTH=4, 6 consecutive writes 0x10..0x15 -> 0x10 on line, 0x11..0x14 queued, 0x15 dropped, overflow=1, and 0x10..0x14 transmitted in order.
REQ-036 SHALL cover write on full with pop: DEPTH=4, FIFO full, write coinciding with the pop cycle -> accepted, level stays 4, and overflow stays 0.
REQ-037 SHALL cover reset mid-frame: rst_n low during DATA bit 3 -> tx=1 with no clock edge, level=0; after release and a write of 0x55 -> clean frame 0x55.
